// File: rtl/csa_result_fifo_if.sv
// Handshake bundle between the CSA result producer, the result FIFO and its consumer.
// The FIFO side uses the slave modport; the producer/consumer side uses the master modport.
interface csa_result_fifo_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
);
    // Push side: sum/cout are taken on a rising edge with in_valid && in_ready.
    // Pop side: the head entry is taken on a rising edge with out_valid && out_ready.
    // in_ready never depends on out_ready, so there is no ready-to-ready path.
    logic [WIDTH-1:0]         sum;
    logic                     cout;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH:0]           out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;
    logic [15:0]              carry_cnt;

    modport slave (
        input  sum, cout, in_valid, out_ready,
        output in_ready, out_data, out_valid, count, full, empty, carry_cnt
    );

    modport master (
        output sum, cout, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count, full, empty, carry_cnt
    );
endinterface

// File: rtl/csa_result_fifo.sv
// Show-ahead FIFO capturing {cout,sum} results from the carry-select adder,
// with occupancy flags and a saturating count of results that carried out.
module csa_result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4   // power of two, at least 2
) (
    input logic               clk,
    input logic               rst,
    csa_result_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH:0]  mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     carry_cnt_q, carry_cnt_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Flags come from registered count only; out_ready cannot reach in_ready.
    always_comb begin
        full  = (count_q == DEPTH_C);
        empty = (count_q == '0);
        push  = bus.in_valid && !full && !rst;
        pop   = bus.out_ready && !empty;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        carry_cnt_d = carry_cnt_q;
        // Pointers are exactly PW bits, so +1 wraps DEPTH-1 back to 0.
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push && bus.cout && (carry_cnt_q != 16'hFFFF)) begin
            carry_cnt_d = carry_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            carry_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    // Storage is not reset; stale slots stay hidden because out_data is masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cout, bus.sum};
        end
    end

    always_comb begin
        bus.in_ready  = !full;
        bus.out_valid = !empty;
        bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
        bus.count     = count_q;
        bus.full      = full;
        bus.empty     = empty;
        bus.carry_cnt = carry_cnt_q;
    end
endmodule

// File: tb/tb_csa_result_fifo.sv
// Directed and randomized checks of csa_result_fifo against a queue-based reference model.
module tb_csa_result_fifo;
  localparam int W = 64;
  localparam int D = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W:0] exp_q[$];
  int   exp_carry;

  csa_result_fifo_if #(.WIDTH(W), .DEPTH(D)) tb_if ();

  csa_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_state();
    logic [W:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("count",     (W+1)'(tb_if.count),     (W+1)'(exp_q.size()));
    check("full",      (W+1)'(tb_if.full),      (W+1)'(exp_q.size() == D));
    check("empty",     (W+1)'(tb_if.empty),     (W+1)'(exp_q.size() == 0));
    check("out_valid", (W+1)'(tb_if.out_valid), (W+1)'(exp_q.size() != 0));
    check("in_ready",  (W+1)'(tb_if.in_ready),  (W+1)'(exp_q.size() < D));
    check("out_data",  tb_if.out_data,          head);
    check("carry_cnt", (W+1)'(tb_if.carry_cnt), (W+1)'(exp_carry));
  endtask

  // One clock of traffic; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic v, input logic [W-1:0] s, input logic c, input logic r,
                      input bit do_chk);
    bit push;
    bit pop;
    tb_if.in_valid  = v;
    tb_if.sum       = s;
    tb_if.cout      = c;
    tb_if.out_ready = r;
    push = v && (exp_q.size() < D);
    pop  = r && (exp_q.size() != 0);
    #1;
    if (do_chk) begin
      check("pre_in_ready", (W+1)'(tb_if.in_ready), (W+1)'(exp_q.size() < D));
    end
    @(posedge clk);
    #1;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back({c, s});
      if (c && exp_carry < 16'hFFFF) exp_carry++;
    end
    tb_if.in_valid  = 1'b0;
    tb_if.out_ready = 1'b0;
    if (do_chk) check_state();
  endtask

  initial begin
    logic [W-1:0] fill_vals[4];
    fill_vals[0] = 64'd24;
    fill_vals[1] = 64'd25;
    fill_vals[2] = 64'd150;
    fill_vals[3] = 64'd3072;
    checks    = 0;
    errors    = 0;
    exp_carry = 0;
    rst             = 1'b1;
    tb_if.in_valid  = 1'b0;
    tb_if.sum       = '0;
    tb_if.cout      = 1'b0;
    tb_if.out_ready = 1'b0;

    // Reset outputs
    #3;
    check_state();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single result
    step(1'b1, 64'd7, 1'b0, 1'b0, 1'b1);
    check("single_data", tb_if.out_data, 65'h0_0000000000000007);
    check("single_count", (W+1)'(tb_if.count), 65'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Fill, then a rejected 5th push
    for (int i = 0; i < 4; i++) step(1'b1, fill_vals[i], 1'b0, 1'b0, 1'b1);
    check("fill_full", (W+1)'(tb_if.full), 65'd1);
    step(1'b1, 64'd24000, 1'b0, 1'b0, 1'b1);
    check("fill_count_held", (W+1)'(tb_if.count), 65'd4);

    // Full with both valid and ready: pop only, in_ready rises afterwards
    step(1'b1, 64'd999, 1'b0, 1'b1, 1'b1);
    check("full_pop_count", (W+1)'(tb_if.count), 65'd3);
    check("full_pop_head", tb_if.out_data, {1'b0, fill_vals[1]});
    step(1'b1, fill_vals[0], 1'b0, 1'b0, 1'b1);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      check("drain_order", tb_if.out_data, {1'b0, fill_vals[(i + 1) % 4]});
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    end
    check("drain_zero", tb_if.out_data, '0);

    // Empty with push and pop: push only
    step(1'b1, 64'd55, 1'b0, 1'b1, 1'b1);
    step(1'b1, 64'd56, 1'b0, 1'b0, 1'b1);

    // Concurrent push/pop at count 2, past pointer wrap
    for (int i = 0; i < 3 * D; i++) begin
      step(1'b1, 64'(100 + i), 1'b0, 1'b1, 1'b1);
      check("conc_count", (W+1)'(tb_if.count), 65'd2);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Carry counting
    for (int i = 0; i < 3; i++) step(1'b1, 64'h0, 1'b1, 1'b0, 1'b1);
    check("carry3", (W+1)'(tb_if.carry_cnt), 65'd3);
    for (int i = 0; i < 3; i++) begin
      check("carry_bit", (W+1)'(tb_if.out_data[W]), 65'd1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    end

    // Asynchronous reset mid-cycle at count 3, with a push during reset
    for (int i = 0; i < 3; i++) step(1'b1, 64'(500 + i), 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_carry = 0;
    check_state();
    tb_if.in_valid = 1'b1;
    tb_if.sum      = 64'd77;
    @(posedge clk);
    #1;
    check("rst_push_ignored", (W+1)'(tb_if.count), 65'd0);
    tb_if.in_valid = 1'b0;
    rst = 1'b0;
    step(1'b1, 64'h1234, 1'b0, 1'b0, 1'b1);
    check("post_rst_data", tb_if.out_data, 65'h1234);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b1);
    end

    // Carry counter saturation
    for (int i = 0; i < 65540; i++) step(1'b1, 64'h5, 1'b1, 1'b1, 1'b0);
    check_state();
    check("carry_sat", (W+1)'(tb_if.carry_cnt), 65'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
